// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 driver (row shift engine and frame/bit-plane sequencer).
package hub75_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } hub75_state_t;

  // Bit position of each colour inside a segment's 3-bit group on the panel data lines
  localparam int RGB_R_BIT = 0;
  localparam int RGB_G_BIT = 1;
  localparam int RGB_B_BIT = 2;

  // Channel field index inside a segment's slice of a memory word; B sits at the LSBs
  localparam int CH_B_FIELD = 0;
  localparam int CH_G_FIELD = 1;
  localparam int CH_R_FIELD = 2;

  localparam int CLK_DIV_W = 4;

  function automatic int word_width(input int segments, input int bpp);
    return segments * 3 * bpp;
  endfunction

endpackage

// File: rtl/hub75_shift_out_if.sv
// Frame-buffer read bus between the row shift engine (master) and the frame memory (slave).
interface hub75_shift_out_if #(
  parameter int addr_width_p = 12,
  parameter int word_width_p = 48
) ();
  logic                    rd_en;
  logic [addr_width_p-1:0] rd_addr;
  logic [word_width_p-1:0] rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/hub75_sclk_phase.sv
// Loadable N-cycle phase timer; o_tc is high in the last cycle of a phase loaded with N-1.
module hub75_sclk_phase #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_len_m1,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_len_m1;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/hub75_shift_out.sv
// HUB75 row shift engine: fetches one row, serialises a bit-plane with a divided sclk, then latches.
module hub75_shift_out
  import hub75_pkg::*;
#(
  parameter int hpixel_p        = 64,
  parameter int vpixel_p        = 64,
  parameter int bpp_p           = 8,
  parameter int segments_p      = 2,
  parameter int addr_width_p    = $clog2(hpixel_p * vpixel_p),
  parameter int pix_bit_width_p = $clog2(bpp_p),
  parameter int row_width_p     = $clog2(vpixel_p / segments_p),
  parameter int word_width_p    = word_width(segments_p, bpp_p)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CLK_DIV_W-1:0]       i_clk_div,
  input  logic                       i_tx_start,
  input  logic [addr_width_p-1:0]    i_init_addr,
  input  logic [pix_bit_width_p-1:0] i_pix_bit,
  output logic                       o_tx_ready,
  output logic                       o_rd_en,
  output logic [addr_width_p-1:0]    o_rd_addr,
  input  logic [word_width_p-1:0]    i_rd_data,
  output logic [segments_p*3-1:0]    o_rgb,
  output logic                       o_sclk,
  output logic                       o_latch,
  output logic [row_width_p-1:0]     o_row_addr
);

  localparam int COL_W = $clog2(hpixel_p);
  localparam int RGB_W = segments_p * 3;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(hpixel_p - 1);

  hub75_state_t                r_state;
  logic [CLK_DIV_W-1:0]        r_len_m1;
  logic [addr_width_p-1:0]     r_base;
  logic [pix_bit_width_p-1:0]  r_pix_bit;
  logic [COL_W-1:0]            r_col;
  logic                        r_rd_vld_p1;
  logic [RGB_W-1:0]            r_stage_p2;

  logic                        w_accept;
  logic                        w_tc;
  logic                        w_ph_load;
  logic                        w_plane_ok;
  logic [RGB_W-1:0]            w_rd_bits;
  logic [RGB_W-1:0]            w_next_rgb;
  logic [addr_width_p-1:0]     w_col_addr;

  assign w_accept   = o_tx_ready & i_tx_start;
  assign w_plane_ok = ({1'b0, r_pix_bit} < (pix_bit_width_p + 1)'(bpp_p));
  assign w_col_addr = r_base + addr_width_p'(r_col);

  // Stage p1: pick the selected bit-plane out of the returned memory word
  for (genvar s = 0; s < segments_p; s++) begin : g_seg
    logic [bpp_p-1:0] w_r, w_g, w_b;
    assign w_r = i_rd_data[s*3*bpp_p + CH_R_FIELD*bpp_p +: bpp_p];
    assign w_g = i_rd_data[s*3*bpp_p + CH_G_FIELD*bpp_p +: bpp_p];
    assign w_b = i_rd_data[s*3*bpp_p + CH_B_FIELD*bpp_p +: bpp_p];
    assign w_rd_bits[3*s + RGB_R_BIT] = w_plane_ok & w_r[r_pix_bit];
    assign w_rd_bits[3*s + RGB_G_BIT] = w_plane_ok & w_g[r_pix_bit];
    assign w_rd_bits[3*s + RGB_B_BIT] = w_plane_ok & w_b[r_pix_bit];
  end

  // With N=1 the next column's data arrives on the very column boundary, bypassing the stage
  assign w_next_rgb = r_rd_vld_p1 ? w_rd_bits : r_stage_p2;

  assign w_ph_load = ((r_state == FETCH) && r_rd_vld_p1) ||
                     (((r_state == SHIFT_LO) || (r_state == SHIFT_HI)) && w_tc);

  hub75_sclk_phase #(
    .CNT_W (CLK_DIV_W)
  ) u_phase (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_ph_load),
    .i_len_m1 (r_len_m1),
    .o_tc     (w_tc)
  );

  // Stage p2: per-transfer settings and staged column bits
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_len_m1  <= i_clk_div;
      r_base    <= i_init_addr;
      r_pix_bit <= i_pix_bit;
    end
    if (r_rd_vld_p1) begin
      r_stage_p2 <= w_rd_bits;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      o_tx_ready  <= 1'b1;
      o_rd_en     <= 1'b0;
      o_rd_addr   <= '0;
      o_rgb       <= '0;
      o_sclk      <= 1'b0;
      o_latch     <= 1'b0;
      o_row_addr  <= '0;
      r_col       <= '0;
      r_rd_vld_p1 <= 1'b0;
    end else begin
      r_rd_vld_p1 <= o_rd_en;
      o_rd_en     <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_tx_start) begin
            r_state    <= FETCH;
            o_tx_ready <= 1'b0;
            o_rd_en    <= 1'b1;
            o_rd_addr  <= i_init_addr;
            r_col      <= '0;
          end
        end
        FETCH: begin
          if (r_rd_vld_p1) begin
            r_state   <= SHIFT_LO;
            o_rgb     <= w_rd_bits;
            o_rd_en   <= 1'b1;
            o_rd_addr <= w_col_addr + addr_width_p'(1);
          end
        end
        SHIFT_LO: begin
          if (w_tc) begin
            r_state <= SHIFT_HI;
            o_sclk  <= 1'b1;
          end
        end
        SHIFT_HI: begin
          if (w_tc) begin
            o_sclk <= 1'b0;
            if (r_col == COL_LAST) begin
              r_state    <= LATCH;
              o_latch    <= 1'b1;
              o_row_addr <= row_width_p'(r_base >> COL_W);
            end else begin
              r_state   <= SHIFT_LO;
              r_col     <= r_col + 1'b1;
              o_rgb     <= w_next_rgb;
              o_rd_en   <= (r_col != (COL_LAST - 1'b1));
              o_rd_addr <= w_col_addr + addr_width_p'(2);
            end
          end
        end
        LATCH: begin
          if (w_tc) begin
            r_state    <= IDLE;
            o_latch    <= 1'b0;
            o_tx_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_shift_out.sv
// Bench for hub75_shift_out: frame memory on the read bus, timing/data model, directed rows.
module tb_hub75_shift_out;

  localparam int H = 64;

  logic        clk;
  logic        rst_n;
  logic [3:0]  clk_div;
  logic        tx_start;
  logic [11:0] init_addr;
  logic [2:0]  pix_bit;
  logic        tx_ready;
  logic [5:0]  rgb;
  logic        sclk;
  logic        latch;
  logic [4:0]  row_addr;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  hub75_shift_out_if #(.addr_width_p(12), .word_width_p(48)) fb ();

  hub75_shift_out dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clk_div   (clk_div),
    .i_tx_start  (tx_start),
    .i_init_addr (init_addr),
    .i_pix_bit   (pix_bit),
    .o_tx_ready  (tx_ready),
    .o_rd_en     (fb.rd_en),
    .o_rd_addr   (fb.rd_addr),
    .i_rd_data   (fb.rd_data),
    .o_rgb       (rgb),
    .o_sclk      (sclk),
    .o_latch     (latch),
    .o_row_addr  (row_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Channel byte stored for address a, segment s, field f (0=B,1=G,2=R).
  // Addresses below 64 hold the column index in every channel.
  function automatic logic [7:0] byte_val(input int a, input int s, input int f);
    int v;
    int aa;
    aa = a & 4095;
    if (aa < 64) return 8'(aa);
    v = (aa * 29 + (s * 3 + f) * 71 + 13) & 255;
    return 8'(v);
  endfunction

  function automatic logic [47:0] mem_word(input int a);
    logic [47:0] w;
    w = '0;
    for (int s = 0; s < 2; s++)
      for (int f = 0; f < 3; f++)
        w[s*24 + f*8 +: 8] = byte_val(a, s, f);
    return w;
  endfunction

  function automatic logic [5:0] exp_bits(input int a, input int pix);
    logic [5:0] o;
    logic [7:0] r, g, b;
    o = '0;
    for (int s = 0; s < 2; s++) begin
      r = byte_val(a, s, 2);
      g = byte_val(a, s, 1);
      b = byte_val(a, s, 0);
      if (pix < 8) begin
        o[3*s]     = r[pix];
        o[3*s + 1] = g[pix];
        o[3*s + 2] = b[pix];
      end
    end
    return o;
  endfunction

  always @(posedge clk)
    fb.rd_data <= fb.rd_en ? mem_word(int'(fb.rd_addr)) : 48'hA5A5_5A5A_C3C3;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Behavioural model: one transfer described by its start cycle and sampled settings
  int m_have = 0, m_t0 = 0, m_n = 1, m_base = 0, m_pix = 0;
  int m_row_before = 0, m_row_new = 0;
  bit m_rgb_zero = 1'b1;

  always @(negedge clk) begin
    int k, endk, lat0, c, ph, e_row;
    bit busy, e_rd;
    k     = cyc - m_t0;
    endk  = 3 + 2 * m_n * H + m_n;
    lat0  = 3 + 2 * m_n * H;
    busy  = (m_have != 0) && k >= 1 && k < endk;
    e_row = ((m_have != 0) && k >= lat0) ? m_row_new : m_row_before;
    if (cyc >= 2) begin
      chk("ready", tx_ready, !busy);
      chk("row", row_addr, e_row);
      if (busy) begin
        c  = (k >= 3) ? (k - 3) / (2 * m_n) : 0;
        ph = (k >= 3) ? (k - 3) % (2 * m_n) : 0;
        e_rd = (k == 1) || (k >= 3 && ph == 0 && c <= H - 2);
        chk("rd_en", fb.rd_en, e_rd);
        if (e_rd) chk("rd_addr", fb.rd_addr, (k == 1) ? m_base : ((m_base + c + 1) & 4095));
        chk("sclk", sclk, (k >= 3 && k < lat0 && ph >= m_n));
        chk("latch", latch, (k >= lat0));
        if (k >= 3) begin
          if (c > H - 1) c = H - 1;
          chk("rgb", rgb, exp_bits(m_base + c, m_pix));
        end
      end else begin
        chk("rd_en_idle", fb.rd_en, 0);
        chk("sclk_idle", sclk, 0);
        chk("latch_idle", latch, 0);
        if (m_rgb_zero) chk("rgb_rst", rgb, 0);
      end
    end
    if (!rst_n) begin
      m_have       = 0;
      m_row_before = 0;
      m_rgb_zero   = 1'b1;
    end else if (tx_start && !busy) begin
      m_row_before = e_row;
      m_have       = 1;
      m_t0         = cyc;
      m_n          = int'(clk_div) + 1;
      m_base       = int'(init_addr);
      m_pix        = int'(pix_bit);
      m_row_new    = (int'(init_addr) >> 6) & 31;
      m_rgb_zero   = 1'b0;
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic neg_at(input int n);
    wait_cyc(n);
    @(negedge clk);
  endtask

  task automatic start_row(input int n, input int div, input int addr, input int pb);
    wait_cyc(n);
    tx_start  = 1'b1;
    clk_div   = 4'(div);
    init_addr = 12'(addr);
    pix_bit   = 3'(pb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end

  initial begin
    int T, U, V, W, X;
    rst_n = 1'b0; tx_start = 1'b0; clk_div = '0; init_addr = '0; pix_bit = '0;
    wait_cyc(4);
    rst_n = 1'b1;
    neg_at(6);
    chk("idle_ready", tx_ready, 1);
    chk("idle_rgb", rgb, 0);

    // Row A: N=1, base 0, plane 0, with starts while busy
    T = 8;
    start_row(T, 0, 0, 0);
    wait_cyc(T + 1); tx_start = 1'b0;
    wait_cyc(T + 10); tx_start = 1'b1;
    wait_cyc(T + 11); tx_start = 1'b0;
    @(negedge clk); chk("A_busy_ready", tx_ready, 0);
    neg_at(T + 13);
    chk("A_rgb_col5", rgb, 6'h3F);
    chk("A_sclk_lo", sclk, 0);
    neg_at(T + 14); chk("A_sclk_hi", sclk, 1);
    start_row(T + 131, 0, 0, 0);
    @(negedge clk);
    chk("A_latch_131", latch, 1);
    chk("A_ready_131", tx_ready, 0);

    // Row B back-to-back: N=4, row 5, MSB plane; settings disturbed mid-row
    U = T + 132;
    start_row(U, 3, 5 * 64, 7);
    @(negedge clk);
    chk("A_ready_132", tx_ready, 1);
    chk("A_row", row_addr, 0);
    wait_cyc(U + 1); tx_start = 1'b0;
    neg_at(U + 3); chk("B_rgb_col0", rgb, 6'h0B);
    neg_at(U + 6); chk("B_sclk_lo", sclk, 0);
    neg_at(U + 7); chk("B_sclk_hi", sclk, 1);
    wait_cyc(U + 100);
    clk_div = 4'd0; pix_bit = 3'd2; init_addr = 12'h555;
    neg_at(U + 515);
    chk("B_row", row_addr, 5);
    chk("B_latch", latch, 1);
    neg_at(U + 518); chk("B_ready_518", tx_ready, 0);
    neg_at(U + 519); chk("B_ready_519", tx_ready, 1);

    // Row D: address wraps past the top of the frame buffer
    V = U + 525;
    start_row(V, 0, 4085, 3);
    wait_cyc(V + 1); tx_start = 1'b0;
    neg_at(V + 23);
    chk("D_wrap_rd_en", fb.rd_en, 1);
    chk("D_wrap_addr", fb.rd_addr, 0);
    neg_at(V + 131); chk("D_row", row_addr, 31);

    // Row C: reset during column 20
    W = V + 140;
    start_row(W, 1, 2883, 4);
    wait_cyc(W + 1); tx_start = 1'b0;
    wait_cyc(W + 84); rst_n = 1'b0;
    wait_cyc(W + 85); rst_n = 1'b1;
    @(negedge clk);
    chk("C_rst_sclk", sclk, 0);
    chk("C_rst_rgb", rgb, 0);
    chk("C_rst_ready", tx_ready, 1);
    chk("C_rst_latch", latch, 0);
    chk("C_rst_row", row_addr, 0);

    // Row E: recovery after reset
    X = W + 290;
    start_row(X, 0, 135, 1);
    wait_cyc(X + 1); tx_start = 1'b0;
    neg_at(X + 131); chk("E_row", row_addr, 2);
    neg_at(X + 132); chk("E_ready", tx_ready, 1);
    wait_cyc(X + 140);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hub75_shift_out.md
# hub75_shift_out

Row shift engine for the HUB75 driver. Sits directly downstream of the frame/bit-plane sequencer. On each accepted `i_tx_start` it:
- reads one display row (all segments in parallel) from the frame buffer;
- serialises bit-plane `i_pix_bit` onto the panel RGB lines with a divided shift clock;
- pulses latch and updates the row address;
- then reports ready again.

## Interface
Parameters:
- `hpixel_p`, 64, display width in pixels (power of two)
- `vpixel_p`, 64, display height in pixels
- `bpp_p`, 8, bits per colour channel
- `segments_p`, 2, panel segments shifted in parallel
- derived: `addr_width_p = $clog2(hpixel_p*vpixel_p)`, `pix_bit_width_p = $clog2(bpp_p)`, `row_width_p = $clog2(vpixel_p/segments_p)`, `word_width_p = segments_p*3*bpp_p`

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: synchronous, active-low reset
- `i_clk_div` in 4: shift-clock half-period minus one, N = `i_clk_div`+1 cycles
- `i_tx_start` in 1: start request, one-cycle pulse
- `i_init_addr` in `addr_width_p`: frame-buffer address of column 0 of the row
- `i_pix_bit` in `pix_bit_width_p`: bit-plane index to shift
- `o_tx_ready` out 1: idle, start accepted
- `o_rd_en` out 1: frame-buffer read strobe
- `o_rd_addr` out `addr_width_p`: frame-buffer read address
- `i_rd_data` in `word_width_p`: read data, valid exactly 1 cycle after `o_rd_en`
- `o_rgb` out `segments_p*3`: panel data; bit 3s+0=R, 3s+1=G, 3s+2=B of segment s
- `o_sclk` out 1: panel shift clock, panel samples on rising edge
- `o_latch` out 1: panel latch
- `o_row_addr` out `row_width_p`: panel row select (A..E)

## Operation
- Reset values: `o_tx_ready`=1, `o_rd_en`=0, `o_rd_addr`=0, `o_rgb`=0, `o_sclk`=0, `o_latch`=0, `o_row_addr`=0, state IDLE.
- A start is accepted only when `i_tx_start`=1 and `o_tx_ready`=1. A start while busy is ignored, with no queueing.
- On acceptance the block samples `i_init_addr`, `i_pix_bit` and `i_clk_div`. Later changes to these inputs have no effect until the next start.
- Memory word layout: segment s occupies `[s*3*bpp_p +: 3*bpp_p]`, ordered {R,G,B} with B at the LSBs. Output bit = channel field bit `i_pix_bit`. If `i_pix_bit` ≥ `bpp_p`, the output is 0.
- Column c read address = `i_init_addr`+c, modulo 2^`addr_width_p`.
- Row address = (`i_init_addr` >> log2(`hpixel_p`)) modulo 2^`row_width_p`.
- FSM states and transitions:
  - IDLE -> FETCH on accepted start.
  - FETCH: issues the column-0 read.
  - SHIFT_LO: holds data, sclk low for N cycles. Issues the next column's read in its first cycle. Read data is captured into a staging register the following cycle.
  - SHIFT_HI: sclk high for N cycles, then SHIFT_LO for the next column. After the last column, goes to LATCH.
  - LATCH: `o_latch`=1 for N cycles with sclk low. `o_row_addr` updates in the first LATCH cycle.
  - LATCH -> IDLE.
- No read is issued after column `hpixel_p`-1. `o_rgb` holds the last column's value through LATCH.
- Reset mid-transfer: all outputs take reset values on the next edge. No latch pulse is produced.

## Timing
- Start accepted at cycle 0. `o_tx_ready`=0 from cycle 1.
- Cycle 1: `o_rd_en`=1, `o_rd_addr`=init. Cycle 3: column-0 data on `o_rgb`, SHIFT_LO begins.
- Column c: low phase at cycles 3+2Nc .. 3+2Nc+N-1, high phase for the next N cycles. `o_rgb` is stable across the whole 2N window.
- LATCH: cycles 3+2NH .. 3+2NH+N-1, where H = `hpixel_p`.
- `o_tx_ready`=1 at cycle 3+2NH+N. Example: H=64, N=1 gives ready at cycle 132.
- A start in that same ready cycle is accepted, for back-to-back rows.

## Structure
- Package `hub75_pkg`:
  - state typedef (IDLE, FETCH, SHIFT_LO, SHIFT_HI, LATCH);
  - R/G/B bit-index constants;
  - `word_width` function.
  - Shared with the sequencer.
- Sub-module `hub75_sclk_phase`: loadable N-cycle phase counter with a terminal-count pulse, reused for both sclk phases and the latch phase.

## Test plan
- Reset, then idle: all outputs at reset values, `o_tx_ready`=1, no `o_rd_en`.
- H=64, N=1, init_addr=0, pix_bit=0, memory word = column index replicated: 64 sclk rising edges; `o_rgb` matches bit 0 of each channel; latch on cycle 131; ready on cycle 132; `o_row_addr`=0.
- i_clk_div=3 (N=4), init_addr=5*64, pix_bit=7: sclk period 8 cycles; `o_row_addr`=5; MSB plane shifted; ready on cycle 3+512+4=519.
- Start pulses while busy at cycles 10 and 131: both ignored. Start at the ready cycle: accepted with no idle gap.
- `i_clk_div` and `i_pix_bit` changed mid-row: no effect on the current row's timing or data.
- rst_n low during column 20: next cycle `o_sclk`=0, `o_rgb`=0, `o_latch` never pulses, `o_tx_ready`=1.
